bcd_conv: RTL and testbench
===========================

BCD_CONV -- requirements
Module: bcd_conv

Interface
REQ-001 SHALL have parameter DIN_W, default 24: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 8: number of BCD output digits, legal range 1..10.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port din_sign  input  1: sign of din (1 = negative), sampled with din.
REQ-006 SHALL have port din  input  DIN_W: unsigned magnitude to convert.
REQ-007 SHALL have port din_vld  input  1: request strobe; sampled only while busy=0.
REQ-008 SHALL have port busy  output  1: high while a conversion is in progress.
REQ-009 SHALL have port dout_sign  output  1: registered sign aligned with dout.
REQ-010 SHALL have port dout  output  4*DIGITS: BCD digits, digit 0 (units) in bits [3:0].
REQ-011 SHALL have port dout_vld  output  1: one-cycle pulse marking new dout.
REQ-012 SHALL have port ovf  output  1: registered with dout; set when din > 10^DIGITS-1.

Function
REQ-013 SHALL implement an iterative shift-and-add-3 (double-dabble) converter with FSM states IDLE, SHIFT and DONE; no divide or modulo operators.
REQ-014 In IDLE with din_vld=1, SHALL capture din and din_sign on edge E0, clear the BCD accumulator and enter SHIFT.
REQ-015 SHIFT SHALL last exactly DIN_W cycles: each cycle, add 3 to every accumulator digit >= 5, then shift left one bit, taking the MSB of the remaining input.
REQ-016 Any 1 bit shifted out of the top digit during SHIFT SHALL set an internal overflow flag.
REQ-017 After the last shift, SHALL enter DONE for one cycle.
REQ-018 On edge E0+DIN_W+1, SHALL load dout, dout_sign and ovf, pulse dout_vld high for one cycle and return to IDLE.
REQ-019 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; back-to-back requests therefore start every DIN_W+2 cycles.
REQ-020 din_vld while busy=1 SHALL be ignored without side effects, and no request SHALL be queued.
REQ-021 din_vld during the cycle in which dout_vld=1 SHALL be accepted, because the FSM is in IDLE.
REQ-022 On overflow, SHALL set ovf=1 and saturate dout to all digits 4'h9.
REQ-023 When the converted magnitude is zero, SHALL force dout_sign to 0 (no negative zero).
REQ-024 Between conversions, dout, dout_sign and ovf SHALL hold their last values.

Reset
REQ-025 rst_n=0 SHALL immediately force the FSM to IDLE, busy=0, dout_vld=0, dout=0, dout_sign=0, ovf=0, and clear all internal registers.
REQ-026 A reset during SHIFT or DONE SHALL abort the conversion, and no dout_vld SHALL follow for that request.
REQ-027 The first din_vld SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro BCD_LZB_EN defined: SHALL replace each leading zero digit of dout with blank code 4'hF when the result is loaded; digit 0 is never blanked; saturated overflow output is never blanked.
REQ-029 Macro BCD_LZB_EN undefined: dout SHALL carry plain BCD including leading zeros.

Verification
REQ-030 Defaults, din=123456, din_sign=0, one-cycle din_vld -> dout=32'h00123456, ovf=0, dout_vld exactly 25 edges after the accept edge, busy high for those 25 cycles.
REQ-031 Defaults, din=24'hFFFFFF -> dout=32'h16777215, ovf=0; then DIGITS=6, din=1000000 -> dout=24'h999999, ovf=1.
REQ-032 Defaults, din=0, din_sign=1 -> dout=32'h00000000, dout_sign=0; din=9, din_sign=1 -> dout_sign=1.
REQ-033 din_vld=1 held continuously with values 5, 7 -> conversions start every 26 cycles; din_vld cycles while busy=1 produce no extra dout_vld.
REQ-034 rst_n pulsed low 10 cycles after accept -> no dout_vld, all outputs 0; a new request after reset converts correctly.
REQ-035 With BCD_LZB_EN defined, din=42 -> dout=32'hFFFFFF42; din=0 -> dout=32'hFFFFFFF0.

Source files
------------

// File: rtl/bcd_conv.sv
// Iterative double-dabble binary-to-BCD converter (IDLE/SHIFT/DONE), one bit per cycle.
// Optional leading-zero blanking when BCD_LZB_EN is defined.
module bcd_conv #(
  parameter int unsigned DIN_W  = 24,
  parameter int unsigned DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din_sign,
  input  logic [DIN_W-1:0]      din,
  input  logic                  din_vld,
  output logic                  busy,
  output logic                  dout_sign,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  dout_vld,
  output logic                  ovf
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [DIN_W-1:0]   r_din;
  logic               r_sign;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_start;
  logic               w_last;
  logic               w_zero;
  logic [ACC_W-1:0]   w_adj;
  logic [ACC_W-1:0]   w_fmt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    w_start = 1'b0;
    w_last  = (r_cnt == CNT_W'(DIN_W - 1));
    case (r_state)
      IDLE: begin
        if (din_vld) begin
          w_start = 1'b1;
          w_next  = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    w_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      else                         w_adj[4*i +: 4] = r_acc[4*i +: 4];
    end
  end

  assign w_zero = (r_acc == '0) && !r_ovf;

  always_comb begin
    w_fmt = r_ovf ? {DIGITS{4'h9}} : r_acc;
`ifdef BCD_LZB_EN
    if (!r_ovf) begin
      // Blank from the top down until the first non-zero digit; digit 0 always shown.
      for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
        if (w_fmt[4*(DIGITS-1-k) +: 4] == 4'h0 &&
            (k == 0 || w_fmt[4*(DIGITS-k) +: 4] == 4'hF))
          w_fmt[4*(DIGITS-1-k) +: 4] = 4'hF;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din     <= '0;
      r_sign    <= 1'b0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
      dout      <= '0;
      dout_sign <= 1'b0;
      ovf       <= 1'b0;
      dout_vld  <= 1'b0;
    end else begin
      dout_vld <= (r_state == DONE);
      if (w_start) begin
        r_din  <= din;
        r_sign <= din_sign;
        r_acc  <= '0;
        r_ovf  <= 1'b0;
        r_cnt  <= '0;
      end else if (r_state == SHIFT) begin
        r_acc <= {w_adj[ACC_W-2:0], r_din[DIN_W-1]};
        r_din <= r_din << 1;
        r_ovf <= r_ovf | w_adj[ACC_W-1];
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == DONE) begin
        dout      <= w_fmt;
        dout_sign <= r_sign & ~w_zero;
        ovf       <= r_ovf;
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv.sv
// Directed self-checking bench for bcd_conv: an 8-digit and a 6-digit instance share stimulus.
module tb_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din_sign;
  logic [23:0] din;
  logic        din_vld;
  logic        busy, dout_sign, dout_vld, ovf;
  logic [31:0] dout;
  logic        busy6, dout_sign6, dout_vld6, ovf6;
  logic [23:0] dout6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_conv #(.DIN_W(24), .DIGITS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din_sign(din_sign), .din(din), .din_vld(din_vld),
    .busy(busy), .dout_sign(dout_sign), .dout(dout), .dout_vld(dout_vld), .ovf(ovf)
  );

  bcd_conv #(.DIN_W(24), .DIGITS(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .din_sign(din_sign), .din(din), .din_vld(din_vld),
    .busy(busy6), .dout_sign(dout_sign6), .dout(dout6), .dout_vld(dout_vld6), .ovf(ovf6)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // Expected 8-digit output: plain value, or the blanked form when the feature is built in.
  function automatic logic [31:0] e8(input logic [31:0] plain, input logic [31:0] blanked);
`ifdef BCD_LZB_EN
    return blanked;
`else
    return plain;
`endif
  endfunction

  task automatic run_conv(input logic [23:0] d, input logic s, output int lat, output int bcnt);
    @(negedge clk);
    din = d; din_sign = s; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    lat = 0; bcnt = 0;
    while (!dout_vld && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat, bcnt, pulses;
  int pidx[$];
  logic [31:0] pval[$];

  initial begin
    rst_n = 1'b0; din = '0; din_sign = 1'b0; din_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_vld", {31'b0, dout_vld}, 32'h0);
    check("rst_ovf_sign", {30'b0, ovf, dout_sign}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    run_conv(24'd123456, 1'b0, lat, bcnt);
    check("lat_123456", lat, 25);
    check("busy_cycles", bcnt, 25);
    check("dout_123456", dout, e8(32'h00123456, 32'hFF123456));
    check("ovf_123456", {31'b0, ovf}, 32'h0);
    check("d6_123456", {8'h0, dout6}, 32'h00123456);
    check("d6_vld_aligned", {31'b0, dout_vld6}, 32'h1);
    @(posedge clk); #1;
    check("vld_one_cycle", {31'b0, dout_vld}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("dout_hold", dout, e8(32'h00123456, 32'hFF123456));

    run_conv(24'hFFFFFF, 1'b0, lat, bcnt);
    check("dout_max", dout, 32'h16777215);
    check("ovf_max", {31'b0, ovf}, 32'h0);
    check("d6_max_sat", {8'h0, dout6}, 32'h00999999);
    check("d6_max_ovf", {31'b0, ovf6}, 32'h1);

    run_conv(24'd1000000, 1'b0, lat, bcnt);
    check("dout_1e6", dout, e8(32'h01000000, 32'hF1000000));
    check("d6_1e6_sat", {8'h0, dout6}, 32'h00999999);
    check("d6_1e6_ovf", {31'b0, ovf6}, 32'h1);

    run_conv(24'd999999, 1'b1, lat, bcnt);
    check("d6_999999", {8'h0, dout6}, 32'h00999999);
    check("d6_999999_ovf", {31'b0, ovf6}, 32'h0);
    check("d6_999999_sign", {31'b0, dout_sign6}, 32'h1);

    run_conv(24'd0, 1'b1, lat, bcnt);
    check("dout_zero", dout, e8(32'h00000000, 32'hFFFFFFF0));
    check("sign_zero", {31'b0, dout_sign}, 32'h0);

    run_conv(24'd9, 1'b1, lat, bcnt);
    check("dout_9", dout, e8(32'h00000009, 32'hFFFFFFF9));
    check("sign_9", {31'b0, dout_sign}, 32'h1);

    run_conv(24'd42, 1'b0, lat, bcnt);
    check("dout_42", dout, e8(32'h00000042, 32'hFFFFFF42));
    check("sign_42", {31'b0, dout_sign}, 32'h0);

    // din_vld held high: second value presented while busy must wait for the next accept.
    @(negedge clk);
    din = 24'd5; din_sign = 1'b0; din_vld = 1'b1;
    @(posedge clk); #1;
    din = 24'd7;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (dout_vld) begin
        pidx.push_back(k);
        pval.push_back(dout);
      end
    end
    din_vld = 1'b0;
    check("hold_pulses", pidx.size(), 2);
    if (pidx.size() >= 2) begin
      check("hold_t0", pidx[0], 25);
      check("hold_v0", pval[0], e8(32'h00000005, 32'hFFFFFFF5));
      check("hold_t1", pidx[1], 51);
      check("hold_v1", pval[1], e8(32'h00000007, 32'hFFFFFFF7));
    end
    repeat (30) @(posedge clk);

    // Reset mid-conversion aborts it.
    @(negedge clk);
    din = 24'd777; din_sign = 1'b1; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    check("arst_dout", dout, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_flags", {29'b0, ovf, dout_sign, dout_vld}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (dout_vld) pulses++;
    end
    check("abort_no_vld", pulses, 0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    run_conv(24'd321, 1'b0, lat, bcnt);
    check("post_rst_lat", lat, 25);
    check("post_rst_dout", dout, e8(32'h00000321, 32'hFFFFF321));

    // Request present as reset releases is taken on the first rising edge.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; din = 24'd55; din_sign = 1'b0; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    check("first_edge_accept", {31'b0, busy}, 32'h1);
    lat = 0;
    while (!dout_vld && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_edge_lat", lat, 25);
    check("first_edge_dout", dout, e8(32'h00000055, 32'hFFFFFF55));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
